// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and defaults: producer select enum, ROB-id conventions, arbitration helper.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_FIFO_DEPTH  = 4;
  localparam int unsigned CDB_ROB_ID_W    = 4;
  localparam int unsigned CDB_DATA_W      = 32;
  localparam int unsigned CDB_ROB_ID_NONE = 0;

  typedef enum logic {
    SRC_RSS = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  // Round-robin pick between two candidates; rr only matters when both want the bus.
  function automatic src_e pick_src(input logic cand_rss, input logic cand_lsb, input src_e rr);
    if (cand_rss && cand_lsb) return rr;
    if (cand_lsb) return SRC_LSB;
    return SRC_RSS;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Synchronous producer FIFO: push/pop/flush with registered count and combinational head/true-full.
module cdb_arbiter_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign head_c = mem_q[rd_ptr_q];
  assign count  = count_q;

  // A push into a full FIFO only lands when the same cycle also pops.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = en && !flush && pop && (count_q != '0);
    do_push  = en && !flush && push && (!full_c || do_pop);
    if (en && flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-producer CDB arbiter: per-producer FIFOs drained round-robin onto a registered broadcast.
// Optional same-cycle bypass of empty FIFOs with CDB_ARBITER_BYPASS_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int unsigned ROB_ID_W   = CDB_ROB_ID_W,
  parameter int unsigned DATA_W     = CDB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                reset_from_rob_bus,
  input  logic [ROB_ID_W-1:0] dest_from_rss,
  input  logic [DATA_W-1:0]   value_from_rss,
  input  logic [DATA_W-1:0]   next_pc_from_rss,
  input  logic [ROB_ID_W-1:0] dest_from_lsb,
  input  logic [DATA_W-1:0]   value_from_lsb,
  output logic [ROB_ID_W-1:0] dest_to_cdb,
  output logic [DATA_W-1:0]   value_to_cdb,
  output logic [DATA_W-1:0]   next_pc_to_cdb,
  output logic                is_rss_fifo_full,
  output logic                is_lsb_fifo_full,
  output logic                overflow_err
);

  localparam int unsigned ENTRY_W = ROB_ID_W + 2 * DATA_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0]  rss_in, lsb_in, rss_head_c, lsb_head_c, win_entry;
  logic [CNT_W-1:0]    rss_count, lsb_count;
  logic                rss_full_c, lsb_full_c;
  logic                rss_vld, lsb_vld, rss_byp, lsb_byp;
  logic                cand_rss, cand_lsb, grant_any, rss_grant, lsb_grant;
  logic                rss_push, rss_pop, lsb_push, lsb_pop;
  src_e                rr_q, rr_d, winner;
  logic [ROB_ID_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic [DATA_W-1:0]   next_pc_q, next_pc_d;
  logic                overflow_q, overflow_d;

  cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_rss_fifo (
    .clk(clk), .rst(rst), .en(rdy), .flush(reset_from_rob_bus),
    .push(rss_push), .pop(rss_pop), .din(rss_in),
    .head_c(rss_head_c), .count(rss_count), .full_c(rss_full_c)
  );

  cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_lsb_fifo (
    .clk(clk), .rst(rst), .en(rdy), .flush(reset_from_rob_bus),
    .push(lsb_push), .pop(lsb_pop), .din(lsb_in),
    .head_c(lsb_head_c), .count(lsb_count), .full_c(lsb_full_c)
  );

  // Pre-full leaves one slot for the result a producer may already have in flight.
  assign is_rss_fifo_full = (rss_count >= CNT_W'(FIFO_DEPTH - 1));
  assign is_lsb_fifo_full = (lsb_count >= CNT_W'(FIFO_DEPTH - 1));

  always_comb begin
    rss_in  = {dest_from_rss, value_from_rss, next_pc_from_rss};
    lsb_in  = {dest_from_lsb, value_from_lsb, DATA_W'(0)};
    rss_vld = (dest_from_rss != ROB_ID_W'(CDB_ROB_ID_NONE));
    lsb_vld = (dest_from_lsb != ROB_ID_W'(CDB_ROB_ID_NONE));
    rss_byp = 1'b0;
    lsb_byp = 1'b0;
`ifdef CDB_ARBITER_BYPASS_EN
    rss_byp = rss_vld && (rss_count == '0);
    lsb_byp = lsb_vld && (lsb_count == '0);
`endif
    cand_rss  = (rss_count != '0) || rss_byp;
    cand_lsb  = (lsb_count != '0) || lsb_byp;
    grant_any = cand_rss || cand_lsb;
    winner    = pick_src(cand_rss, cand_lsb, rr_q);
    rss_grant = grant_any && (winner == SRC_RSS);
    lsb_grant = grant_any && (winner == SRC_LSB);
    // A bypassed winner skips its FIFO entirely; a bypassed loser enqueues as usual.
    rss_pop   = rss_grant && !rss_byp;
    lsb_pop   = lsb_grant && !lsb_byp;
    rss_push  = rss_vld && !(rss_grant && rss_byp);
    lsb_push  = lsb_vld && !(lsb_grant && lsb_byp);

    win_entry = '0;
    if (rss_grant)      win_entry = rss_byp ? rss_in : rss_head_c;
    else if (lsb_grant) win_entry = lsb_byp ? lsb_in : lsb_head_c;

    rr_d       = rr_q;
    dest_d     = dest_q;
    value_d    = value_q;
    next_pc_d  = next_pc_q;
    overflow_d = overflow_q;
    if (rdy) begin
      if (reset_from_rob_bus) begin
        rr_d      = SRC_RSS;
        dest_d    = '0;
        value_d   = '0;
        next_pc_d = '0;
      end else begin
        if (grant_any) rr_d = (winner == SRC_RSS) ? SRC_LSB : SRC_RSS;
        {dest_d, value_d, next_pc_d} = win_entry;
        if ((rss_push && rss_full_c && !rss_pop) || (lsb_push && lsb_full_c && !lsb_pop))
          overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= SRC_RSS;
      dest_q     <= '0;
      value_q    <= '0;
      next_pc_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      dest_q     <= dest_d;
      value_q    <= value_d;
      next_pc_q  <= next_pc_d;
      overflow_q <= overflow_d;
    end
  end

  assign dest_to_cdb    = dest_q;
  assign value_to_cdb   = value_q;
  assign next_pc_to_cdb = next_pc_q;
  assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed literal checks.
module tb_cdb_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  d;
    logic [31:0] v;
    logic [31:0] p;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        reset_from_rob_bus;
  logic [3:0]  dest_from_rss, dest_from_lsb;
  logic [31:0] value_from_rss, next_pc_from_rss, value_from_lsb;
  logic [3:0]  dest_to_cdb;
  logic [31:0] value_to_cdb, next_pc_to_cdb;
  logic        is_rss_fifo_full, is_lsb_fifo_full, overflow_err;

  int n_chk  = 0;
  int n_pass = 0;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_ID_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
    .dest_from_rss(dest_from_rss), .value_from_rss(value_from_rss),
    .next_pc_from_rss(next_pc_from_rss),
    .dest_from_lsb(dest_from_lsb), .value_from_lsb(value_from_lsb),
    .dest_to_cdb(dest_to_cdb), .value_to_cdb(value_to_cdb), .next_pc_to_cdb(next_pc_to_cdb),
    .is_rss_fifo_full(is_rss_fifo_full), .is_lsb_fifo_full(is_lsb_fifo_full),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: plain queues and a round-robin bit, updated at each clock edge.
  ent_t qr[$], ql[$];
  ent_t e_out = '0;
  ent_t inr, inl, win;
  bit   m_rr = 1'b0, e_ovf = 1'b0, bcast_new = 1'b0;
  bit   br, bl, cr, cl, wr, wl;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      qr.delete(); ql.delete();
      m_rr = 1'b0; e_out = '0; e_ovf = 1'b0; bcast_new = 1'b0;
    end else begin
      bcast_new = rdy;
      if (rdy && reset_from_rob_bus) begin
        qr.delete(); ql.delete();
        m_rr = 1'b0; e_out = '0;
      end else if (rdy) begin
        inr = '{d: dest_from_rss, v: value_from_rss, p: next_pc_from_rss};
        inl = '{d: dest_from_lsb, v: value_from_lsb, p: 32'h0};
        br = 1'b0; bl = 1'b0;
`ifdef CDB_ARBITER_BYPASS_EN
        br = (qr.size() == 0) && (inr.d != 4'd0);
        bl = (ql.size() == 0) && (inl.d != 4'd0);
`endif
        cr = (qr.size() > 0) || br;
        cl = (ql.size() > 0) || bl;
        wr = cr && (!cl || !m_rr);
        wl = cl && !wr;
        win = '0;
        if (wr) begin win = br ? inr : qr.pop_front(); m_rr = 1'b1; end
        if (wl) begin win = bl ? inl : ql.pop_front(); m_rr = 1'b0; end
        e_out = win;
        if (inr.d != 4'd0 && !(wr && br)) begin
          if (qr.size() < DEPTH) qr.push_back(inr); else e_ovf = 1'b1;
        end
        if (inl.d != 4'd0 && !(wl && bl)) begin
          if (ql.size() < DEPTH) ql.push_back(inl); else e_ovf = 1'b1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge; also log each fresh broadcast.
  bit          chk_en = 1'b0;
  logic [3:0]  seen[$];
  logic [31:0] seen_pc[$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cdb_dest", 64'(dest_to_cdb), 64'(e_out.d));
      check("cdb_value", 64'(value_to_cdb), 64'(e_out.v));
      check("cdb_next_pc", 64'(next_pc_to_cdb), 64'(e_out.p));
      check("rss_prefull", 64'(is_rss_fifo_full), 64'(qr.size() >= DEPTH - 1));
      check("lsb_prefull", 64'(is_lsb_fifo_full), 64'(ql.size() >= DEPTH - 1));
      check("overflow", 64'(overflow_err), 64'(e_ovf));
      if (bcast_new && dest_to_cdb != 4'd0) begin
        seen.push_back(dest_to_cdb);
        seen_pc.push_back(next_pc_to_cdb);
      end
    end
  end

  task automatic drive(input logic [3:0] rd, input logic [31:0] rv, input logic [31:0] rp,
                       input logic [3:0] ld, input logic [31:0] lv, input logic fl);
    dest_from_rss = rd; value_from_rss = rv; next_pc_from_rss = rp;
    dest_from_lsb = ld; value_from_lsb = lv; reset_from_rob_bus = fl;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0);
  endtask

`ifdef CDB_ARBITER_BYPASS_EN
  localparam int EXP_FULL_K = 4;
  localparam int EXP_OVF_K  = 8;
  localparam logic [3:0] EXP_FROZEN = 4'd12;
`else
  localparam int EXP_FULL_K = 3;
  localparam int EXP_OVF_K  = 7;
  localparam logic [3:0] EXP_FROZEN = 4'd10;
`endif

  logic [3:0]  exp_ord[4];
  logic [31:0] exp_pc[4];
  int          full_k, ovf_k;

  initial begin
    rdy = 1'b1; reset_from_rob_bus = 1'b0;
    dest_from_rss = '0; value_from_rss = '0; next_pc_from_rss = '0;
    dest_from_lsb = '0; value_from_lsb = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_dest", 64'(dest_to_cdb), 64'd0);
    check("reset_lsb_full", 64'(is_lsb_fifo_full), 64'd0);
    check("reset_overflow", 64'(overflow_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_en = 1'b1;

    // Single source latency
    drive(4'd3, 32'h11, 32'h104, 4'd0, 32'd0, 1'b0);
`ifdef CDB_ARBITER_BYPASS_EN
    check("single_dest_e0", 64'(dest_to_cdb), 64'd3);
    check("single_value_e0", 64'(value_to_cdb), 64'h11);
    check("single_pc_e0", 64'(next_pc_to_cdb), 64'h104);
    idle();
    check("single_dest_e1", 64'(dest_to_cdb), 64'd0);
`else
    check("single_dest_e0", 64'(dest_to_cdb), 64'd0);
    idle();
    check("single_dest_e1", 64'(dest_to_cdb), 64'd3);
    check("single_value_e1", 64'(value_to_cdb), 64'h11);
    check("single_pc_e1", 64'(next_pc_to_cdb), 64'h104);
`endif
    idle();
    check("single_dest_after", 64'(dest_to_cdb), 64'd0);

    // Contention: flush first so rr starts at rss
    drive(4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b1);
    seen.delete(); seen_pc.delete();
    drive(4'd1, 32'hA1, 32'h200, 4'd5, 32'hB5, 1'b0);
    drive(4'd2, 32'hA2, 32'h204, 4'd6, 32'hB6, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    exp_ord = '{4'd1, 4'd5, 4'd2, 4'd6};
    exp_pc  = '{32'h200, 32'h0, 32'h204, 32'h0};
    check("contend_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      check($sformatf("contend_dest%0d", i), 64'(seen[i]), 64'(exp_ord[i]));
      check($sformatf("contend_pc%0d", i), 64'(seen_pc[i]), 64'(exp_pc[i]));
    end

    // Back-pressure: both producers push every cycle, ignoring the flags
    full_k = -1; ovf_k = -1;
    for (int k = 0; k < 10; k++) begin
      drive(4'((k % 7) + 1), 32'(k), 32'(k * 4), 4'((k % 7) + 8), 32'(k + 100), 1'b0);
      if (full_k < 0 && is_lsb_fifo_full) full_k = k;
      if (ovf_k < 0 && overflow_err) ovf_k = k;
    end
    check("bp_lsb_full_edge", 64'(full_k), 64'(EXP_FULL_K));
    check("bp_overflow_edge", 64'(ovf_k), 64'(EXP_OVF_K));

    // Flush with a concurrent push
    drive(4'd9, 32'h99, 32'h990, 4'd9, 32'h98, 1'b1);
    check("flush_dest", 64'(dest_to_cdb), 64'd0);
    check("flush_rss_full", 64'(is_rss_fifo_full), 64'd0);
    check("flush_lsb_full", 64'(is_lsb_fifo_full), 64'd0);
    check("flush_keeps_overflow", 64'(overflow_err), 64'd1);
    seen.delete(); seen_pc.delete();
    for (int i = 0; i < 4; i++) idle();
    check("flush_nothing_broadcast", 64'(seen.size()), 64'd0);

    // rdy stall
    seen.delete(); seen_pc.delete();
    drive(4'd10, 32'h10A, 32'h300, 4'd12, 32'h1C, 1'b0);
    drive(4'd11, 32'h10B, 32'h304, 4'd0, 32'd0, 1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("stall_dest%0d", i), 64'(dest_to_cdb), 64'(EXP_FROZEN));
    end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    exp_ord[0] = 4'd10; exp_ord[1] = 4'd12; exp_ord[2] = 4'd11;
    check("stall_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++)
      check($sformatf("stall_order%0d", i), 64'(seen[i]), 64'(exp_ord[i]));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      drive(4'(i + 1), 32'(i), 32'(i), 4'(i + 8), 32'(i), 1'b0);
    check("pre_reset_overflow", 64'(overflow_err), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_dest", 64'(dest_to_cdb), 64'd0);
    check("async_reset_rss_full", 64'(is_rss_fifo_full), 64'd0);
    check("async_reset_lsb_full", 64'(is_lsb_fifo_full), 64'd0);
    check("async_reset_overflow", 64'(overflow_err), 64'd0);
    dest_from_rss = '0; dest_from_lsb = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    seen.delete(); seen_pc.delete();
    for (int i = 0; i < 4; i++) idle();
    check("post_reset_silent", 64'(seen.size()), 64'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the two result producers, the reservation-station ALU path and the load/store buffer. Each producer writes into a private FIFO, and a round-robin scheduler drains one entry per cycle onto a registered broadcast. The ROB, the reservation station and the issuer all consume that broadcast. Producers are throttled with pre-full flags, and a ROB reset flushes everything in flight.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries per producer FIFO; must be a power of two and at least 2.
- ROB_ID_W, 4: width of a ROB id. Id 0 is reserved and means "no result".
- DATA_W, 32: width of the value and next_pc fields.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- reset_from_rob_bus  in  1  mispredict flush, synchronous
- dest_from_rss  in  ROB_ID_W  ALU result tag; nonzero means valid
- value_from_rss  in  DATA_W  ALU result value
- next_pc_from_rss  in  DATA_W  ALU computed next pc
- dest_from_lsb  in  ROB_ID_W  load result tag; nonzero means valid
- value_from_lsb  in  DATA_W  load result value
- dest_to_cdb  out  ROB_ID_W  broadcast tag; 0 means idle
- value_to_cdb  out  DATA_W  broadcast value
- next_pc_to_cdb  out  DATA_W  broadcast next pc; driven as 0 for LSB entries
- is_rss_fifo_full  out  1  ALU producer must not present a new result
- is_lsb_fifo_full  out  1  LSB producer must not present a new result
- overflow_err  out  1  sticky flag: a result arrived while its FIFO was truly full

## Operation
- **Enqueue.** A nonzero dest_from_X pushes {dest, value, next_pc} into FIFO X at the clock edge. The LSB FIFO stores next_pc as 0.
- **Candidates.** A source is a candidate when its FIFO is non-empty; the candidate entry is the FIFO head.
- **Grant.** At most one source wins per cycle.
  - If only one source is a candidate, it wins.
  - If both are candidates, the winner is the source that round-robin pointer rr points at (0 = rss, 1 = lsb).
  - After a grant, rr becomes the opposite of the winner.
  - rr resets to 0.
- **Dequeue and output.** The winning head pops. dest/value/next_pc_to_cdb register the winner's entry. If there is no winner, all three outputs register 0.
- **Simultaneous push and pop on one FIFO.** The count is unchanged, and both operations take effect.
- **Pointers and count.**
  - Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
  - The count is log2(FIFO_DEPTH)+1 bits wide.
- **Pre-full flags.** is_X_fifo_full is combinational and equals (count_X >= FIFO_DEPTH-1). The pre-full threshold absorbs the producer's one-cycle response delay.
- **Overflow.** A push while count_X == FIFO_DEPTH and no pop on X that cycle drops the incoming entry and sets overflow_err. Only rst clears overflow_err.
- **ROB flush.** While reset_from_rob_bus is high, at the next edge:
  - both FIFOs empty and rr is set to 0;
  - all CDB outputs become 0;
  - inputs presented in that cycle are discarded.
  - overflow_err is not cleared.
- **rdy low.** No push, no pop and no output update occur. Producers are frozen by the same rdy.

## Timing
- **Reset.** rst asserted clears, asynchronously:
  - all CDB outputs to 0;
  - overflow_err to 0;
  - counts and pointers to 0;
  - rr to 0.
- **Latency without bypass.** A result pushed at edge E is eligible at E+1 and appears on the CDB after edge E+1, provided it wins.
- **Uncontended throughput.** One broadcast per cycle sustained from a single source.
- **Contended throughput.** Sources alternate, one broadcast each per cycle pair.
- **Flags.** The full flags follow the count in the same cycle; there is no extra register stage.

## Configuration
- Macro: CDB_ARBITER_BYPASS_EN.
- **Defined.**
  - An incoming result whose FIFO is empty is also a candidate that same cycle.
  - If it wins, it goes directly to the CDB registers at edge E and is never written to the FIFO, giving one-edge latency.
  - If it loses, it is enqueued normally.
  - Arbitration rules are unchanged.
- **Undefined.** Latency is always two edges as specified in Timing.

## Structure
- config.v carries the shared macros: ROB id width, register width, FIFO_DEPTH default, and the "id 0 = invalid" convention. These are shared with the reservation station, LS buffer and ROB.
- One sub-module, cdb_fifo: a parameterised synchronous FIFO with push, pop, flush, head data, count and true-full.
  - It is instantiated twice.
  - The arbiter top holds rr, grant logic, the output registers and overflow_err.

## Test plan
1. **Reset.** Assert rst mid-stream with 3 entries queued -> outputs, flags and overflow_err go to 0 immediately; no broadcast after release.
2. **Single source.** Push rss dest=3, value=0x11, next_pc=0x104 at edge 0 -> dest_to_cdb=3, value=0x11, next_pc=0x104 after edge 1 (after edge 0 with CDB_ARBITER_BYPASS_EN). dest returns to 0 the following cycle.
3. **Contention.** Push rss dest=1,2 and lsb dest=5,6 on consecutive edges -> broadcast order 1,5,2,6, with next_pc=0 on the lsb entries.
4. **Back-pressure.** FIFO_DEPTH=4; push 3 lsb results while the rss FIFO keeps winning -> is_lsb_fifo_full rises at count 3. A 5th push at count 4 is dropped and sets overflow_err.
5. **Flush.** 2 entries queued, plus a new push, in the cycle reset_from_rob_bus=1 -> next cycle both FIFOs are empty, dest_to_cdb=0, the pushed entry never appears, and overflow_err keeps its value.
6. **rdy stall.** Drop rdy for 3 cycles with entries queued -> outputs and counts are frozen. On rdy=1, draining resumes in the original order.
